// File: rtl/sd_wb_arb_pkg.sv
// Shared types and constants for the SD controller Wishbone master arbiter.
package sd_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        NEXT = 2'd2
    } arb_state_e;

    localparam logic OWN_TX = 1'b0;
    localparam logic OWN_RX = 1'b1;

    localparam logic [3:0] SEL_ALL = 4'hF;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return (owner == OWN_RX) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sd_wb_watchdog.sv
// Strobe watchdog: counts unacknowledged strobe cycles and flags the last one allowed.
module sd_wb_watchdog
    import sd_wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/sd_wb_master_arb.sv
// Round-robin arbiter sharing the Wishbone master port between the TX filler (reads)
// and the RX drainer (writes), with a per-grant burst limit and an ack watchdog.
module sd_wb_master_arb
    import sd_wb_arb_pkg::*;
#(
    parameter int BURST_MAX = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        tx_req_i,
    input  logic [31:0] tx_adr_i,
    output logic [31:0] tx_dat_o,
    output logic        tx_ack_o,
    output logic        tx_err_o,
    input  logic        rx_req_i,
    input  logic [31:0] rx_adr_i,
    input  logic [31:0] rx_dat_i,
    output logic        rx_ack_o,
    output logic        rx_err_o,
    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i,
    output logic [1:0]  grant_o
);

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    arb_state_e state, state_next;
    logic       owner, last_owner;
    logic [7:0] beat_cnt;

    logic grant_win, beat_owner, owner_req;
    logic start_beat, ack_hit, timeout, release_grant;
    logic wd_clr, wd_en, wd_expire;
    logic xfer_ack;

    sd_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    assign owner_req  = (owner == OWN_RX) ? rx_req_i : tx_req_i;
    assign beat_owner = (state == IDLE) ? grant_win : owner;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        grant_win     = OWN_TX;
        start_beat    = 1'b0;
        ack_hit       = 1'b0;
        timeout       = 1'b0;
        release_grant = 1'b0;
        wd_clr        = 1'b0;
        wd_en         = 1'b0;
        case (state)
            IDLE: begin
                if (tx_req_i || rx_req_i) begin
                    if (tx_req_i && rx_req_i) begin
                        grant_win = ~last_owner;
                    end else begin
                        grant_win = rx_req_i ? OWN_RX : OWN_TX;
                    end
                    start_beat = 1'b1;
                    wd_clr     = 1'b1;
                    state_next = XFER;
                end
            end
            XFER: begin
                // An ack on the expiry cycle completes the beat rather than erroring it.
                if (m_wb_ack_i) begin
                    ack_hit    = 1'b1;
                    state_next = NEXT;
                end else if (wd_expire) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else begin
                    wd_en = 1'b1;
                end
            end
            NEXT: begin
                if (owner_req && (beat_cnt < BURST_LIM)) begin
                    start_beat = 1'b1;
                    wd_clr     = 1'b1;
                    state_next = XFER;
                end else begin
                    release_grant = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            owner      <= OWN_TX;
            last_owner <= OWN_RX;
            beat_cnt   <= '0;
            m_wb_adr_o <= '0;
            m_wb_dat_o <= '0;
            m_wb_we_o  <= 1'b0;
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            m_wb_sel_o <= '0;
            grant_o    <= '0;
            tx_err_o   <= 1'b0;
            rx_err_o   <= 1'b0;
        end else begin
            state    <= state_next;
            tx_err_o <= timeout && (owner == OWN_TX);
            rx_err_o <= timeout && (owner == OWN_RX);

            if (state == IDLE && start_beat) begin
                owner    <= grant_win;
                beat_cnt <= '0;
            end else if (ack_hit) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (start_beat) begin
                m_wb_adr_o <= (beat_owner == OWN_RX) ? rx_adr_i : tx_adr_i;
                m_wb_dat_o <= (beat_owner == OWN_RX) ? rx_dat_i : '0;
                m_wb_we_o  <= (beat_owner == OWN_RX);
            end

            if (release_grant || timeout) begin
                last_owner <= owner;
            end

            m_wb_cyc_o <= (state_next != IDLE);
            m_wb_stb_o <= (state_next == XFER);
            m_wb_sel_o <= (state_next != IDLE) ? SEL_ALL : 4'h0;
            grant_o    <= (state_next != IDLE) ? owner_onehot(beat_owner) : 2'b00;
        end
    end

    assign xfer_ack = (state == XFER) && m_wb_ack_i && !wb_rst_i;
    assign tx_ack_o = xfer_ack && (owner == OWN_TX);
    assign rx_ack_o = xfer_ack && (owner == OWN_RX);
    assign tx_dat_o = tx_ack_o ? m_wb_dat_i : '0;

endmodule

// File: tb/tb_sd_wb_master_arb.sv
// Self-checking bench for sd_wb_master_arb: vector table, directed corner cases and
// a randomized run checked against a rule-level model of the arbiter.
module tb_sd_wb_master_arb;
    import sd_wb_arb_pkg::*;

    localparam int BURST = 4;
    localparam int TMO   = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        tx_req = 1'b0, rx_req = 1'b0;
    logic [31:0] tx_adr = '0, rx_adr = '0, rx_dat = '0;
    logic [31:0] tx_dat_o;
    logic        tx_ack_o, tx_err_o, rx_ack_o, rx_err_o;
    logic [31:0] m_wb_adr_o, m_wb_dat_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
    logic [31:0] m_wb_dat_i = '0;
    logic        m_wb_ack_i = 1'b0;
    logic [1:0]  grant_o;

    int checks = 0;
    int errors = 0;

    sd_wb_master_arb #(.BURST_MAX(BURST), .TIMEOUT(TMO)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .tx_req_i   (tx_req),
        .tx_adr_i   (tx_adr),
        .tx_dat_o   (tx_dat_o),
        .tx_ack_o   (tx_ack_o),
        .tx_err_o   (tx_err_o),
        .rx_req_i   (rx_req),
        .rx_adr_i   (rx_adr),
        .rx_dat_i   (rx_dat),
        .rx_ack_o   (rx_ack_o),
        .rx_err_o   (rx_err_o),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_dat_o (m_wb_dat_o),
        .m_wb_sel_o (m_wb_sel_o),
        .m_wb_we_o  (m_wb_we_o),
        .m_wb_cyc_o (m_wb_cyc_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_dat_i (m_wb_dat_i),
        .m_wb_ack_i (m_wb_ack_i),
        .grant_o    (grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Per-cycle vector: inputs, then expected observations.
    typedef struct packed {
        logic       tx_req;
        logic       rx_req;
        logic       ack;
        logic [1:0] grant;
        logic       cyc;
        logic       stb;
        logic       tx_ack;
        logic       rx_ack;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge and outputs sampled 1 unit later.
    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    function automatic logic [12:0] ctl_bits();
        return {m_wb_cyc_o, m_wb_stb_o, grant_o, m_wb_sel_o, m_wb_we_o,
                tx_err_o, rx_err_o, tx_ack_o, rx_ack_o};
    endfunction

    task automatic do_reset();
        step();
        wb_rst_i   = 1'b1;
        tx_req     = 1'b0;
        rx_req     = 1'b0;
        m_wb_ack_i = 1'b0;
        m_wb_dat_i = '0;
        step();
        step();
        #1;
        check("reset_ctl", {19'd0, ctl_bits()}, 32'd0);
        check("reset_adr", m_wb_adr_o, 32'd0);
        check("reset_dat", m_wb_dat_o, 32'd0);
        check("reset_txdat", tx_dat_o, 32'd0);
        wb_rst_i = 1'b0;
    endtask

    task automatic run_table();
        tx_adr = 32'h0000_0100;
        rx_adr = 32'h0000_0200;
        rx_dat = 32'hA5A5_0001;
        for (int i = 0; i < 20; i++) begin
            step();
            tx_req     = vecs[i].tx_req;
            rx_req     = vecs[i].rx_req;
            m_wb_ack_i = vecs[i].ack;
            #1;
            check($sformatf("vec[%0d]", i),
                  {25'd0, grant_o, m_wb_cyc_o, m_wb_stb_o, tx_ack_o, rx_ack_o, tx_err_o | rx_err_o},
                  {25'd0, vecs[i].grant, vecs[i].cyc, vecs[i].stb, vecs[i].tx_ack, vecs[i].rx_ack, 1'b0});
        end
    endtask

    task automatic test_single_tx();
        do_reset();
        step();
        tx_req = 1'b1;
        tx_adr = 32'h0000_1000;
        #1;
        check("tx1_idle_cyc", {31'd0, m_wb_cyc_o}, 32'd0);
        step();
        m_wb_ack_i = 1'b1;
        m_wb_dat_i = 32'hDEAD_BEEF;
        #1;
        check("tx1_stb_we", {30'd0, m_wb_stb_o, m_wb_we_o}, 32'd2);
        check("tx1_adr", m_wb_adr_o, 32'h0000_1000);
        check("tx1_acks", {30'd0, tx_ack_o, rx_ack_o}, 32'd2);
        check("tx1_dat", tx_dat_o, 32'hDEAD_BEEF);
        step();
        m_wb_ack_i = 1'b0;
        tx_req     = 1'b0;
        #1;
        check("tx1_next", {29'd0, m_wb_cyc_o, m_wb_stb_o, tx_ack_o}, 32'd4);
        step();
        #1;
        check("tx1_release", {29'd0, m_wb_cyc_o, grant_o}, 32'd0);
    endtask

    task automatic test_rx_wait();
        do_reset();
        step();
        rx_req = 1'b1;
        rx_adr = 32'h0000_2000;
        rx_dat = 32'h1234_5678;
        #1;
        for (int k = 1; k <= 4; k++) begin
            step();
            m_wb_ack_i = (k == 4);
            #1;
            check($sformatf("rxw_stb_we[%0d]", k), {30'd0, m_wb_stb_o, m_wb_we_o}, 32'd3);
            check($sformatf("rxw_adr[%0d]", k), m_wb_adr_o, 32'h0000_2000);
            check($sformatf("rxw_dat[%0d]", k), m_wb_dat_o, 32'h1234_5678);
            check($sformatf("rxw_ack[%0d]", k), {30'd0, rx_ack_o, tx_ack_o}, {30'd0, (k == 4), 1'b0});
        end
        step();
        m_wb_ack_i = 1'b0;
        rx_req     = 1'b0;
        #1;
        check("rxw_next", {30'd0, m_wb_cyc_o, m_wb_stb_o}, 32'd2);
        step();
        #1;
        check("rxw_release", {31'd0, m_wb_cyc_o}, 32'd0);
    endtask

    task automatic test_timeout();
        int n_stb = 0, n_ack = 0, n_err = 0, cyc_at_err = 1;
        logic [1:0] grant_after = 2'b11;
        logic       err_prev = 1'b0;
        do_reset();
        step();
        tx_req = 1'b1;
        tx_adr = 32'h0000_3000;
        #1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (err_prev) tx_req = 1'b0;
            if (k == 5) begin
                rx_req = 1'b1;
                rx_adr = 32'h0000_4000;
            end
            if (rx_ack_o) rx_req = 1'b0;
            m_wb_ack_i = m_wb_stb_o && (grant_o == 2'b10);
            #1;
            if (err_prev) grant_after = grant_o;
            if (m_wb_stb_o && grant_o == 2'b01) n_stb++;
            if (tx_ack_o) n_ack++;
            if (tx_err_o) begin
                n_err++;
                cyc_at_err = m_wb_cyc_o;
            end
            err_prev = tx_err_o;
        end
        m_wb_ack_i = 1'b0;
        check("tmo_stb_cycles", n_stb, TMO);
        check("tmo_no_ack", n_ack, 0);
        check("tmo_err_pulses", n_err, 1);
        check("tmo_cyc_at_err", cyc_at_err, 0);
        check("tmo_tie_to_rx", {30'd0, grant_after}, 32'd2);
    endtask

    task automatic test_ack_on_expiry();
        int n_stb = 0, n_ack = 0, n_err = 0;
        do_reset();
        step();
        tx_req = 1'b1;
        tx_adr = 32'h0000_5000;
        #1;
        for (int k = 0; k < 24; k++) begin
            step();
            if (n_ack > 0) tx_req = 1'b0;
            m_wb_ack_i = m_wb_stb_o && (n_stb == TMO - 1);
            #1;
            if (m_wb_stb_o) n_stb++;
            if (tx_ack_o) n_ack++;
            if (tx_err_o) n_err++;
        end
        m_wb_ack_i = 1'b0;
        check("exp_stb_cycles", n_stb, TMO);
        check("exp_ack", n_ack, 1);
        check("exp_no_err", n_err, 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        step();
        tx_req = 1'b1;
        tx_adr = 32'h0000_6000;
        #1;
        step();
        #1;
        check("rstm_in_xfer", {31'd0, m_wb_stb_o}, 32'd1);
        step();
        wb_rst_i = 1'b1;
        #1;
        step();
        wb_rst_i = 1'b0;
        tx_req   = 1'b0;
        #1;
        check("rstm_ctl", {19'd0, ctl_bits()}, 32'd0);
        check("rstm_adr", m_wb_adr_o, 32'd0);
        step();
        m_wb_ack_i = 1'b1;
        #1;
        check("rstm_stray_ack", {19'd0, ctl_bits()}, 32'd0);
        step();
        m_wb_ack_i = 1'b0;
        #1;
        check("rstm_idle", {19'd0, ctl_bits()}, 32'd0);
    endtask

    // Rule-level model: each observation is predicted from the previous cycle's inputs
    // and observations using the arbitration, burst and timeout rules.
    task automatic run_random(input int ncyc);
        logic        p_txr = 1'b0, p_rxr = 1'b0, p_ack = 1'b0, p_stb = 1'b0;
        logic [1:0]  p_grant = 2'b00;
        logic [31:0] p_txa = '0, p_rxa = '0, p_rxd = '0;
        logic        last_m = OWN_RX, own_m = OWN_TX;
        int          beats = 0, run = 0;
        logic [31:0] b_adr = '0, b_dat = '0;
        logic        dead = 1'b0, tx_got = 1'b0, rx_got = 1'b0;
        logic [1:0]  e_grant;
        logic        e_stb, e_cyc, new_beat, e_txerr, e_rxerr;
        do_reset();
        for (int k = 0; k < ncyc; k++) begin
            step();
            if (tx_req) begin
                if (tx_got) begin
                    if ($urandom_range(3) != 0) tx_adr = $urandom() & 32'hFFFF_FFFC;
                    else tx_req = 1'b0;
                end
            end else if ($urandom_range(2) == 0) begin
                tx_req = 1'b1;
                tx_adr = $urandom() & 32'hFFFF_FFFC;
            end
            if (rx_req) begin
                if (rx_got) begin
                    if ($urandom_range(3) != 0) begin
                        rx_adr = $urandom() & 32'hFFFF_FFFC;
                        rx_dat = $urandom();
                    end else begin
                        rx_req = 1'b0;
                    end
                end
            end else if ($urandom_range(2) == 0) begin
                rx_req = 1'b1;
                rx_adr = $urandom() & 32'hFFFF_FFFC;
                rx_dat = $urandom();
            end
            if (!m_wb_stb_o) dead = ($urandom_range(11) == 0);
            m_wb_ack_i = m_wb_stb_o ? (!dead && $urandom_range(2) == 0) : ($urandom_range(7) == 0);
            m_wb_dat_i = $urandom();
            #1;

            e_grant  = p_grant;
            e_stb    = 1'b0;
            e_txerr  = 1'b0;
            e_rxerr  = 1'b0;
            new_beat = 1'b0;
            if (p_grant == 2'b00) begin
                if (p_txr || p_rxr) begin
                    own_m    = (p_txr && p_rxr) ? ~last_m : p_rxr;
                    beats    = 0;
                    new_beat = 1'b1;
                end
            end else if (p_stb) begin
                if (p_ack) begin
                    beats++;
                end else if (run == TMO) begin
                    e_grant = 2'b00;
                    e_txerr = (own_m == OWN_TX);
                    e_rxerr = (own_m == OWN_RX);
                end else begin
                    e_stb = 1'b1;
                end
            end else begin
                if (((own_m == OWN_RX) ? p_rxr : p_txr) && beats < BURST) new_beat = 1'b1;
                else e_grant = 2'b00;
            end
            if (new_beat) begin
                e_stb   = 1'b1;
                e_grant = (own_m == OWN_RX) ? 2'b10 : 2'b01;
                b_adr   = (own_m == OWN_RX) ? p_rxa : p_txa;
                b_dat   = p_rxd;
                run     = 0;
            end
            if (p_grant != 2'b00 && e_grant == 2'b00) last_m = own_m;
            e_cyc = (e_grant != 2'b00);

            check("rnd_bus", {24'd0, grant_o, m_wb_cyc_o, m_wb_stb_o, m_wb_sel_o},
                  {24'd0, e_grant, e_cyc, e_stb, e_cyc ? SEL_ALL : 4'h0});
            check("rnd_ack", {30'd0, tx_ack_o, rx_ack_o},
                  {30'd0, e_stb && m_wb_ack_i && own_m == OWN_TX, e_stb && m_wb_ack_i && own_m == OWN_RX});
            check("rnd_err", {30'd0, tx_err_o, rx_err_o}, {30'd0, e_txerr, e_rxerr});
            if (e_stb) begin
                check("rnd_adr", m_wb_adr_o, b_adr);
                check("rnd_we", {31'd0, m_wb_we_o}, {31'd0, own_m == OWN_RX});
                if (own_m == OWN_RX) check("rnd_wdat", m_wb_dat_o, b_dat);
                if (m_wb_ack_i && own_m == OWN_TX) check("rnd_rdat", tx_dat_o, m_wb_dat_i);
            end

            if (e_stb) run++;
            tx_got  = tx_ack_o || tx_err_o;
            rx_got  = rx_ack_o || rx_err_o;
            p_txr   = tx_req;
            p_rxr   = rx_req;
            p_txa   = tx_adr;
            p_rxa   = rx_adr;
            p_rxd   = rx_dat;
            p_ack   = m_wb_ack_i;
            p_stb   = m_wb_stb_o;
            p_grant = grant_o;
        end
        m_wb_ack_i = 1'b0;
        tx_req     = 1'b0;
        rx_req     = 1'b0;
    endtask

    initial begin
        // tx, rx, ack | grant, cyc, stb, tx_ack, rx_ack; acks in NEXT and IDLE are strays.
        vecs = '{
            9'b1_1_0_00_0_0_0_0,
            9'b1_1_1_01_1_1_1_0,
            9'b1_1_1_01_1_0_0_0,
            9'b1_1_1_01_1_1_1_0,
            9'b1_1_0_01_1_0_0_0,
            9'b1_1_1_01_1_1_1_0,
            9'b1_1_0_01_1_0_0_0,
            9'b1_1_1_01_1_1_1_0,
            9'b1_1_0_01_1_0_0_0,
            9'b1_1_1_00_0_0_0_0,
            9'b1_1_1_10_1_1_0_1,
            9'b1_1_0_10_1_0_0_0,
            9'b1_1_1_10_1_1_0_1,
            9'b1_1_0_10_1_0_0_0,
            9'b1_1_1_10_1_1_0_1,
            9'b1_1_0_10_1_0_0_0,
            9'b1_1_1_10_1_1_0_1,
            9'b1_1_0_10_1_0_0_0,
            9'b1_1_0_00_0_0_0_0,
            9'b1_1_1_01_1_1_1_0
        };

        do_reset();
        run_table();
        test_single_tx();
        test_rx_wait();
        test_timeout();
        test_ack_on_expiry();
        test_reset_mid();
        run_random(4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
